// File: rtl/vote_collector.sv
// Ballot collection stage for the four-voter majority evaluator.
// Latency: a vote edge in cycle n is visible on votes/voted at n+1, and the session closes at n+1
//   (after the last vote or the timeout cycle).
// Backpressure: none. Votes are edge-triggered and are locked once taken; start is ignored while OPEN.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             opens a session from IDLE or DONE (level, sampled each cycle)
//   vote_req/vote_val per-voter request (taken on a 0->1 transition) and the choice sampled with it
//   votes/voted       ballot word for the downstream evaluator I[3:0], and the has-voted flags
//   busy/done         the session is OPEN / the ballot is final
//   done_pulse        high for the first DONE cycle only
//   timed_out         the session closed on the timer with at least one voter absent
module vote_collector #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_req,
  input  logic [3:0] vote_val,
  output logic [3:0] votes,
  output logic [3:0] voted,
  output logic       busy,
  output logic       done,
  output logic       done_pulse,
  output logic       timed_out
);

  typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

  // Terminal timer value. TIMEOUT_CYC may be 2^CNT_W, so TIMEOUT_CYC-1 is the largest value that fits.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nx;
  logic [3:0]       req_q;
  logic [3:0]       accept;
  logic [3:0]       voted_nx;
  logic [CNT_W-1:0] timer;
  logic             all_in;
  logic             expire;
  logic             opening;
  logic             closing;

  always_comb begin
    // Only a fresh rising edge from a voter who has not yet voted is taken.
    accept   = vote_req & ~req_q & ~voted;
    voted_nx = voted | accept;
    all_in   = (voted_nx == 4'b1111);
    expire   = (timer == LAST);
    state_nx = state;
    opening  = 1'b0;
    closing  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = OPEN;
          opening  = 1'b1;
        end
      end
      OPEN: begin
        if (all_in || expire) begin
          state_nx = DONE;
          closing  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nx = OPEN;
          opening  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      votes      <= '0;
      voted      <= '0;
      timed_out  <= 1'b0;
      done_pulse <= 1'b0;
      timer      <= '0;
    end else begin
      // The history tracks the request lines in every state, so a line held high
      // across session entry has to fall and rise again before it counts.
      req_q      <= vote_req;
      done_pulse <= closing;
      if (opening) begin
        votes     <= '0;
        voted     <= '0;
        timed_out <= 1'b0;
        timer     <= '0;
      end else if (state == OPEN) begin
        voted <= voted_nx;
        votes <= (votes & ~accept) | (vote_val & accept);
        timer <= timer + 1'b1;
        // A full ballot has priority over an expiring timer in the same cycle.
        if (closing) begin
          timed_out <= ~all_in;
        end
      end
    end
  end

  assign busy = (state == OPEN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_vote_collector.sv
module tb_vote_collector;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_req;
  logic [3:0] vote_val;
  logic [3:0] votes, voted, votes1, voted1;
  logic       busy, done, done_pulse, timed_out;
  logic       busy1, done1, done_pulse1, timed_out1;
  logic [11:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: session phase (0 idle, 1 open, 2 done), cycles spent open, and per-voter records.
  int m_phase;
  int m_age;
  bit m_voted[4];
  bit m_votes[4];
  bit m_prev[4];
  bit m_to;
  bit m_pulse;

  vote_collector #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .vote_req(vote_req), .vote_val(vote_val),
    .votes(votes), .voted(voted), .busy(busy), .done(done),
    .done_pulse(done_pulse), .timed_out(timed_out)
  );

  vote_collector #(.TIMEOUT_CYC(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .vote_req(vote_req), .vote_val(vote_val),
    .votes(votes1), .voted(voted1), .busy(busy1), .done(done1),
    .done_pulse(done_pulse1), .timed_out(timed_out1)
  );

  always #5 clk = ~clk;

  assign obs = {votes, voted, busy, done, done_pulse, timed_out};

  function automatic logic [11:0] mexp();
    logic [3:0] vb, db;
    for (int i = 0; i < 4; i++) begin
      vb[i] = m_votes[i];
      db[i] = m_voted[i];
    end
    return {vb, db, (m_phase == 1), (m_phase == 2), m_pulse, m_to};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_to    = 0;
    m_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      m_voted[i] = 0;
      m_votes[i] = 0;
      m_prev[i]  = 0;
    end
  endtask

  task automatic model_step();
    bit all;
    if (m_phase != 1) begin
      m_pulse = 0;
      if (start) begin
        m_phase = 1;
        m_age   = 0;
        m_to    = 0;
        for (int i = 0; i < 4; i++) begin
          m_voted[i] = 0;
          m_votes[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (vote_req[i] && !m_prev[i] && !m_voted[i]) begin
          m_voted[i] = 1;
          m_votes[i] = vote_val[i];
        end
      end
      m_age++;
      all = m_voted[0] && m_voted[1] && m_voted[2] && m_voted[3];
      m_pulse = 0;
      if (all) begin
        m_phase = 2;
        m_to    = 0;
        m_pulse = 1;
      end else if (m_age == TO) begin
        m_phase = 2;
        m_to    = 1;
        m_pulse = 1;
      end
    end
    for (int i = 0; i < 4; i++) m_prev[i] = vote_req[i];
  endtask

  task automatic drive(input bit s, input logic [3:0] rq, input logic [3:0] vv);
    start    = s;
    vote_req = rq;
    vote_val = vv;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 4'b0000, 4'b0000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 4'b0000, 4'b0000);
    model_reset();
    #1;
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL reset_initial got=%b want=%b", obs, 12'd0); end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 4'b0000, 4'b1111);
    step();
    drive(0, 4'b0001, 4'b1111);
    step();
    drive(0, 4'b0011, 4'b1111);
    step();
    n_cmp++;
    if (obs !== mexp() || voted !== 4'b0011) begin
      n_bad++; $display("FAIL reset_pre_votes got=%b want=%b", obs, mexp());
    end
    // Reset away from any clock edge must clear the outputs at once.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL reset_async got=%b want=%b", obs, 12'd0); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 4'b0000, 4'b0000);
    step();
    step();
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL reset_stays_idle got=%b want=%b", obs, 12'd0); end
    drive(1, 4'b0000, 4'b0000);
    step();
    n_cmp++;
    if (busy !== 1'b1 || obs !== mexp()) begin
      n_bad++; $display("FAIL reset_reopen got=%b want=%b", obs, mexp());
    end
  endtask

  task automatic test_all_vote();
    logic [3:0] rq [6];
    int pulses;
    rq[0] = 4'b0000; rq[1] = 4'b0000; rq[2] = 4'b0001;
    rq[3] = 4'b0011; rq[4] = 4'b0111; rq[5] = 4'b1111;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, rq[c], 4'b1011);
      step();
      pulses += int'(done_pulse);
    end
    n_cmp++;
    if (obs !== {4'b1011, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL all_vote_close got=%b want=%b", obs, {4'b1011, 4'b1111, 4'b0110});
    end
    drive(0, 4'b1111, 4'b0000);
    step();
    step();
    pulses += int'(done_pulse);
    n_cmp++;
    if (obs !== mexp() || pulses != 1) begin
      n_bad++; $display("FAIL all_vote_hold got=%b want=%b pulses=%0d want=1", obs, mexp(), pulses);
    end
  endtask

  task automatic test_timeout();
    int open_cycles;
    do_reset();
    drive(1, 4'b0000, 4'b0110);
    step();
    open_cycles = 0;
    while (done !== 1'b1 && open_cycles < 20) begin
      drive(0, (open_cycles >= 1) ? 4'b0110 : 4'b0000, 4'b0110);
      step();
      open_cycles++;
    end
    n_cmp++;
    if (open_cycles != TO) begin
      n_bad++; $display("FAIL timeout_length got=%0d want=%0d", open_cycles, TO);
    end
    n_cmp++;
    if (obs !== {4'b0110, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1} || obs !== mexp()) begin
      n_bad++; $display("FAIL timeout_result got=%b want=%b", obs, {4'b0110, 4'b0110, 4'b0111});
    end
  endtask

  task automatic test_lock_and_held();
    do_reset();
    drive(0, 4'b1000, 4'b0000);
    step();
    drive(1, 4'b1000, 4'b0000);
    step();
    drive(0, 4'b1001, 4'b0001);
    step();
    drive(0, 4'b1000, 4'b0000);
    step();
    drive(0, 4'b1001, 4'b0000);
    step();
    n_cmp++;
    if (votes !== 4'b0001 || voted !== 4'b0001 || obs !== mexp()) begin
      n_bad++; $display("FAIL lock_vote got=%b want=%b", obs, mexp());
    end
    drive(0, 4'b0000, 4'b0000);
    step();
    drive(0, 4'b1000, 4'b1000);
    step();
    n_cmp++;
    if (votes !== 4'b1001 || voted !== 4'b1001 || busy !== 1'b1 || obs !== mexp()) begin
      n_bad++; $display("FAIL held_req_rerise got=%b want=%b", obs, mexp());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 4'b0000, 4'b0101);
    step();
    drive(0, 4'b1111, 4'b0101);
    step();
    n_cmp++;
    if (obs !== {4'b0101, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL simultaneous got=%b want=%b", obs, {4'b0101, 4'b1111, 4'b0110});
    end
    // Last voter arrives in the final OPEN cycle: a full ballot beats the timer.
    do_reset();
    drive(1, 4'b0000, 4'b1010);
    step();
    for (int c = 1; c < TO; c++) begin
      drive(0, 4'b0111, 4'b1010);
      step();
    end
    n_cmp++;
    if (busy !== 1'b1 || voted !== 4'b0111) begin
      n_bad++; $display("FAIL last_cycle_pre got busy=%b voted=%b want busy=1 voted=0111", busy, voted);
    end
    drive(0, 4'b1111, 4'b1010);
    step();
    n_cmp++;
    if (obs !== {4'b1010, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0} || obs !== mexp()) begin
      n_bad++; $display("FAIL last_cycle_vote got=%b want=%b", obs, {4'b1010, 4'b1111, 4'b0110});
    end
  endtask

  task automatic test_back_to_back();
    int pulses, sessions;
    bit was_done;
    pulses = 0;
    sessions = 0;
    was_done = 0;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      drive(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
      pulses += int'(done_pulse);
      sessions += int'(m_pulse);
      n_cmp++;
      if (obs !== mexp()) begin
        n_bad++; $display("FAIL b2b_cyc%0d got=%b want=%b", k, obs, mexp());
      end
      if (was_done) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || voted !== 4'b0000 || votes !== 4'b0000) begin
          n_bad++; $display("FAIL b2b_reopen_cyc%0d got=%b want busy=1 cleared", k, obs);
        end
      end
      was_done = (done === 1'b1);
    end
    n_cmp++;
    if (pulses != sessions || sessions < 3) begin
      n_bad++; $display("FAIL b2b_pulses got=%0d want=%0d (>=3)", pulses, sessions);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
      n_cmp++;
      if (obs !== mexp()) begin
        n_bad++; $display("FAIL rand_cyc%0d got=%b want=%b", k, obs, mexp());
      end
    end
  endtask

  task automatic test_timeout1();
    do_reset();
    drive(1, 4'b0000, 4'b0000);
    step();
    n_cmp++;
    if ({busy1, done1} !== 2'b10) begin
      n_bad++; $display("FAIL to1_open got=%b want=10", {busy1, done1});
    end
    drive(0, 4'b0000, 4'b0000);
    step();
    n_cmp++;
    if ({busy1, done1, done_pulse1, timed_out1, voted1, votes1} !== 12'b0111_0000_0000) begin
      n_bad++; $display("FAIL to1_close got=%b want=011100000000",
                        {busy1, done1, done_pulse1, timed_out1, voted1, votes1});
    end
    step();
    n_cmp++;
    if ({busy1, done1, done_pulse1} !== 3'b010) begin
      n_bad++; $display("FAIL to1_hold got=%b want=010", {busy1, done1, done_pulse1});
    end
  endtask

  initial begin
    test_reset();
    test_all_vote();
    test_timeout();
    test_lock_and_held();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_timeout1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
